// File: rtl/ras_unit.sv
// rtl/ras_unit.sv - return address stack with per-CTI checkpoints; optional RAS_STATS_EN counters
// Branch type encoding: 0 COND, 1 CALL, 2 RETURN, 3 JUMP.
module ras_unit #(
    parameter int RAS_DEPTH   = 16,
    parameter int SIZE_PC     = 32,
    parameter int CTI_DEPTH   = 16,
    parameter int BRANCH_TYPE = 2,
    localparam int RAS_LOG    = $clog2(RAS_DEPTH),
    localparam int CTI_LOG    = $clog2(CTI_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_i,
    input  logic                   fs1Push_i,
    input  logic                   fs1Pop_i,
    input  logic [SIZE_PC-1:0]     fs1CallPC_i,
    input  logic                   fs2RecoverFlag_i,
    input  logic                   fs2MissedCall_i,
    input  logic                   fs2MissedReturn_i,
    input  logic [SIZE_PC-1:0]     fs2CallPC_i,
    input  logic                   ckptEn_i,
    input  logic [CTI_LOG-1:0]     ckptCtiID_i,
    input  logic                   recoverFlag_i,
    input  logic [CTI_LOG-1:0]     recoverCtiID_i,
    input  logic [BRANCH_TYPE-1:0] recoverType_i,
    input  logic [SIZE_PC-1:0]     recoverPC_i,
    input  logic                   exceptionFlag_i,
    output logic [SIZE_PC-1:0]     addrRAS_o,
    output logic                   rasEmpty_o,
    output logic                   rasFull_o
`ifdef RAS_STATS_EN
    ,
    output logic [31:0]            statPush_o,
    output logic [31:0]            statPop_o,
    output logic [31:0]            statOverflow_o,
    output logic [31:0]            statUnderflow_o
`endif
);

    localparam int CNT_W = RAS_LOG + 1;
    localparam logic [CNT_W-1:0]       FULL_CNT  = CNT_W'(RAS_DEPTH);
    localparam logic [BRANCH_TYPE-1:0] BR_CALL   = BRANCH_TYPE'(1);
    localparam logic [BRANCH_TYPE-1:0] BR_RETURN = BRANCH_TYPE'(2);

    logic [SIZE_PC-1:0] stack_q [RAS_DEPTH];
    logic [RAS_LOG-1:0] tos_q, tos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [RAS_LOG-1:0] ck_tos_q [CTI_DEPTH];
    logic [CNT_W-1:0]   ck_cnt_q [CTI_DEPTH];
    logic [SIZE_PC-1:0] ck_top_q [CTI_DEPTH];

    logic [RAS_LOG-1:0] base_tos;
    logic [CNT_W-1:0]   base_cnt;
    logic               do_push, do_pop;
    logic [SIZE_PC-1:0] push_pc;
    logic               rst_en;
    logic [SIZE_PC-1:0] rst_data;
    logic               wr_en;
    logic [RAS_LOG-1:0] wr_idx;
    logic [SIZE_PC-1:0] wr_data;
    logic               ckpt_we;

    assign addrRAS_o  = stack_q[tos_q];
    assign rasEmpty_o = (cnt_q == '0);
    assign rasFull_o  = (cnt_q == FULL_CNT);
    assign ckpt_we    = ckptEn_i && !recoverFlag_i && !exceptionFlag_i;

    always_comb begin
        base_tos = tos_q;
        base_cnt = cnt_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_pc  = fs1CallPC_i;
        rst_en   = 1'b0;
        rst_data = ck_top_q[recoverCtiID_i];
        wr_en    = 1'b0;
        wr_idx   = tos_q;
        wr_data  = '0;
        tos_d    = tos_q;
        cnt_d    = cnt_q;
        if (exceptionFlag_i) begin
            tos_d = '0;
            cnt_d = '0;
        end else begin
            if (recoverFlag_i) begin
                // Rewind to the checkpoint, then replay the resolved CTI on top of it
                base_tos = ck_tos_q[recoverCtiID_i];
                base_cnt = ck_cnt_q[recoverCtiID_i];
                rst_en   = 1'b1;
                do_push  = (recoverType_i == BR_CALL);
                do_pop   = (recoverType_i == BR_RETURN);
                push_pc  = recoverPC_i;
            end else if (fs2RecoverFlag_i) begin
                do_push = fs2MissedCall_i;
                do_pop  = fs2MissedReturn_i && !fs2MissedCall_i;
                push_pc = fs2CallPC_i;
            end else if (!stall_i) begin
                do_push = fs1Push_i;
                do_pop  = fs1Pop_i && !fs1Push_i;
                push_pc = fs1CallPC_i;
            end
            tos_d = base_tos;
            cnt_d = base_cnt;
            if (do_push) begin
                tos_d   = base_tos + RAS_LOG'(1);
                cnt_d   = (base_cnt == FULL_CNT) ? base_cnt : base_cnt + CNT_W'(1);
                wr_en   = 1'b1;
                wr_idx  = base_tos + RAS_LOG'(1);
                wr_data = push_pc + SIZE_PC'(8);
            end else if (do_pop) begin
                tos_d = base_tos - RAS_LOG'(1);
                cnt_d = (base_cnt == '0) ? '0 : base_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
            for (int j = 0; j < CTI_DEPTH; j++) begin
                ck_tos_q[j] <= '0;
                ck_cnt_q[j] <= '0;
                ck_top_q[j] <= '0;
            end
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            // The push target is tos+1, so it never collides with the top repair
            if (rst_en) stack_q[base_tos] <= rst_data;
            if (wr_en)  stack_q[wr_idx]   <= wr_data;
            if (ckpt_we) begin
                ck_tos_q[ckptCtiID_i] <= tos_q;
                ck_cnt_q[ckptCtiID_i] <= cnt_q;
                ck_top_q[ckptCtiID_i] <= stack_q[tos_q];
            end
        end
    end

`ifdef RAS_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statPush_o      <= '0;
            statPop_o       <= '0;
            statOverflow_o  <= '0;
            statUnderflow_o <= '0;
        end else begin
            if (do_push) statPush_o <= statPush_o + 32'd1;
            if (do_pop)  statPop_o  <= statPop_o + 32'd1;
            if (do_push && base_cnt == FULL_CNT) statOverflow_o  <= statOverflow_o + 32'd1;
            if (do_pop && base_cnt == '0)        statUnderflow_o <= statUnderflow_o + 32'd1;
        end
    end
`endif

`ifdef SIM
    a_fs1_excl: assert property (@(posedge clk) disable iff (reset) !(fs1Push_i && fs1Pop_i));
`endif

endmodule

// File: tb/tb_ras_unit.sv
// tb/tb_ras_unit.sv - randomized model-based bench for ras_unit
module tb_ras_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, fs1Push_i, fs1Pop_i;
    logic [31:0] fs1CallPC_i;
    logic        fs2RecoverFlag_i, fs2MissedCall_i, fs2MissedReturn_i;
    logic [31:0] fs2CallPC_i;
    logic        ckptEn_i;
    logic [3:0]  ckptCtiID_i;
    logic        recoverFlag_i;
    logic [3:0]  recoverCtiID_i;
    logic [1:0]  recoverType_i;
    logic [31:0] recoverPC_i;
    logic        exceptionFlag_i;
    logic [31:0] addrRAS_o;
    logic        rasEmpty_o, rasFull_o;
`ifdef RAS_STATS_EN
    logic [31:0] statPush_o, statPop_o, statOverflow_o, statUnderflow_o;
`endif

    ras_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .fs1Push_i(fs1Push_i), .fs1Pop_i(fs1Pop_i), .fs1CallPC_i(fs1CallPC_i),
        .fs2RecoverFlag_i(fs2RecoverFlag_i), .fs2MissedCall_i(fs2MissedCall_i),
        .fs2MissedReturn_i(fs2MissedReturn_i), .fs2CallPC_i(fs2CallPC_i),
        .ckptEn_i(ckptEn_i), .ckptCtiID_i(ckptCtiID_i),
        .recoverFlag_i(recoverFlag_i), .recoverCtiID_i(recoverCtiID_i),
        .recoverType_i(recoverType_i), .recoverPC_i(recoverPC_i),
        .exceptionFlag_i(exceptionFlag_i),
        .addrRAS_o(addrRAS_o), .rasEmpty_o(rasEmpty_o), .rasFull_o(rasFull_o)
`ifdef RAS_STATS_EN
        , .statPush_o(statPush_o), .statPop_o(statPop_o),
        .statOverflow_o(statOverflow_o), .statUnderflow_o(statUnderflow_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a 16-slot circular stack with an occupancy count, kept as plain ints
    logic [31:0] m_stack [16];
    int          m_tos, m_cnt;
    int          ck_tos [16];
    int          ck_cnt [16];
    logic [31:0] ck_top [16];
    int          m_push, m_pop, m_ovf, m_udf;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endfunction

    function automatic void model_reset();
        m_tos = 0; m_cnt = 0;
        m_push = 0; m_pop = 0; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < 16; i++) begin
            m_stack[i] = '0; ck_tos[i] = 0; ck_cnt[i] = 0; ck_top[i] = '0;
        end
    endfunction

    function automatic void model_step();
        bit push, pop;
        logic [31:0] pc;
        push = 0; pop = 0; pc = '0;
        if (ckptEn_i && !recoverFlag_i && !exceptionFlag_i) begin
            ck_tos[ckptCtiID_i] = m_tos;
            ck_cnt[ckptCtiID_i] = m_cnt;
            ck_top[ckptCtiID_i] = m_stack[m_tos];
        end
        if (exceptionFlag_i) begin
            m_tos = 0; m_cnt = 0;
            return;
        end
        if (recoverFlag_i) begin
            m_tos = ck_tos[recoverCtiID_i];
            m_cnt = ck_cnt[recoverCtiID_i];
            m_stack[m_tos] = ck_top[recoverCtiID_i];
            push = (recoverType_i == 2'd1);
            pop  = (recoverType_i == 2'd2);
            pc   = recoverPC_i;
        end else if (fs2RecoverFlag_i) begin
            push = fs2MissedCall_i;
            pop  = fs2MissedReturn_i && !fs2MissedCall_i;
            pc   = fs2CallPC_i;
        end else if (!stall_i) begin
            push = fs1Push_i;
            pop  = fs1Pop_i;
            pc   = fs1CallPC_i;
        end
        if (push) begin
            m_push++;
            if (m_cnt == 16) m_ovf++;
            m_tos = (m_tos + 1) % 16;
            m_stack[m_tos] = pc + 32'd8;
            m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
        end else if (pop) begin
            m_pop++;
            if (m_cnt == 0) m_udf++;
            m_tos = (m_tos + 15) % 16;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
    endfunction

    task automatic idle_inputs();
        stall_i = 0; fs1Push_i = 0; fs1Pop_i = 0; fs1CallPC_i = '0;
        fs2RecoverFlag_i = 0; fs2MissedCall_i = 0; fs2MissedReturn_i = 0; fs2CallPC_i = '0;
        ckptEn_i = 0; ckptCtiID_i = '0; recoverFlag_i = 0; recoverCtiID_i = '0;
        recoverType_i = '0; recoverPC_i = '0; exceptionFlag_i = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic push1(logic [31:0] pc);
        fs1Push_i = 1; fs1CallPC_i = pc; cycle();
    endtask

    task automatic pop1();
        fs1Pop_i = 1; cycle();
    endtask

    task automatic recover(logic [3:0] id, logic [1:0] ty, logic [31:0] pc);
        recoverFlag_i = 1; recoverCtiID_i = id; recoverType_i = ty; recoverPC_i = pc; cycle();
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("addr", addrRAS_o, m_stack[m_tos]);
            chk("empty", 32'(rasEmpty_o), 32'(m_cnt == 0));
            chk("full", 32'(rasFull_o), 32'(m_cnt == 16));
`ifdef RAS_STATS_EN
            chk("stat_push", statPush_o, 32'(m_push));
            chk("stat_pop", statPop_o, 32'(m_pop));
            chk("stat_ovf", statOverflow_o, 32'(m_ovf));
            chk("stat_udf", statUnderflow_o, 32'(m_udf));
`endif
        end
    end

    initial begin
`ifdef RAS_STATS_EN
        int s_push, s_pop;
`endif
        idle_inputs();
        model_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_addr", addrRAS_o, 32'h0);
        chk("reset_empty", 32'(rasEmpty_o), 32'd1);
        chk("reset_full", 32'(rasFull_o), 32'd0);

        push1(32'h1000); push1(32'h2000); push1(32'h3000);
        chk("push3_top", addrRAS_o, 32'h3008);
        pop1();
        chk("pop1_top", addrRAS_o, 32'h2008);
        pop1();
        chk("pop2_model_cnt", 32'(m_cnt), 32'd1);
        chk("pop2_top", addrRAS_o, 32'h1008);
        chk("pop2_not_empty", 32'(rasEmpty_o), 32'd0);

        exceptionFlag_i = 1; cycle();
        chk("exc_addr", addrRAS_o, 32'h0);
        chk("exc_empty", 32'(rasEmpty_o), 32'd1);

        for (int k = 0; k < 17; k++) push1(32'h100 * k);
        chk("full_after_17", 32'(rasFull_o), 32'd1);
        for (int k = 16; k >= 1; k--) begin
            chk("lifo_order", addrRAS_o, 32'h100 * k + 32'd8);
            pop1();
        end
        chk("empty_after_16", 32'(rasEmpty_o), 32'd1);
        pop1();
        chk("underflow_empty", 32'(rasEmpty_o), 32'd1);
        chk("underflow_top", addrRAS_o, 32'h0F08);

        exceptionFlag_i = 1; cycle();
        push1(32'h1000); push1(32'h2000);
        fs1Push_i = 1; fs1CallPC_i = 32'h4000;
        fs2RecoverFlag_i = 1; fs2MissedReturn_i = 1; cycle();
        chk("fs2_squash", addrRAS_o, 32'h1008);
        stall_i = 1; fs1Push_i = 1; fs1CallPC_i = 32'h4000; cycle();
        chk("stall_hold", addrRAS_o, 32'h1008);

        push1(32'h2000);
        ckptEn_i = 1; ckptCtiID_i = 4'd3; fs1Push_i = 1; fs1CallPC_i = 32'h9000; cycle();
        chk("wrong_push", addrRAS_o, 32'h9008);
        pop1(); pop1();
        push1(32'h7000);
        chk("overwrite", addrRAS_o, 32'h7008);
        recover(4'd3, 2'd0, 32'h0);
        chk("rec_cond_top", addrRAS_o, 32'h2008);
        chk("rec_cond_cnt", 32'(m_cnt), 32'd2);
        recover(4'd3, 2'd1, 32'h5000);
        chk("rec_call_top", addrRAS_o, 32'h5008);
        chk("rec_call_cnt", 32'(m_cnt), 32'd3);
        recover(4'd3, 2'd2, 32'h0);
        chk("rec_ret_top", addrRAS_o, 32'h1008);
        chk("rec_ret_cnt", 32'(m_cnt), 32'd1);

`ifdef RAS_STATS_EN
        s_push = m_push; s_pop = m_pop;
`endif
        exceptionFlag_i = 1; recoverFlag_i = 1; recoverCtiID_i = 4'd3; recoverType_i = 2'd1;
        recoverPC_i = 32'h5000; fs1Push_i = 1; fs1CallPC_i = 32'h6000; cycle();
        chk("exc_prio_empty", 32'(rasEmpty_o), 32'd1);
        chk("exc_prio_top", addrRAS_o, 32'h0F08);
`ifdef RAS_STATS_EN
        chk("exc_no_push_stat", statPush_o, 32'(s_push));
        chk("exc_no_pop_stat", statPop_o, 32'(s_pop));
`endif

        for (int n = 0; n < 3000; n++) begin
            int op;
            exceptionFlag_i   = ($urandom_range(0, 59) == 0);
            recoverFlag_i     = ($urandom_range(0, 11) == 0);
            recoverCtiID_i    = 4'($urandom_range(0, 15));
            recoverType_i     = 2'($urandom_range(0, 3));
            recoverPC_i       = $urandom;
            fs2RecoverFlag_i  = ($urandom_range(0, 7) == 0);
            fs2MissedCall_i   = 1'($urandom_range(0, 1));
            fs2MissedReturn_i = 1'($urandom_range(0, 1));
            fs2CallPC_i       = $urandom;
            stall_i           = ($urandom_range(0, 4) == 0);
            op                = $urandom_range(0, 2);
            fs1Push_i         = (op == 1);
            fs1Pop_i          = (op == 2);
            fs1CallPC_i       = $urandom;
            ckptEn_i          = ($urandom_range(0, 2) == 0);
            ckptCtiID_i       = 4'($urandom_range(0, 15));
            cycle();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
